// File: rtl/parity_lane_accumulator_if.sv
// Handshake/bus bundle between the last datapath stage, parity accumulator and parity output buffer.
// Latency: none (wires only). Backpressure: p_ready from the output buffer.
// PARITY_INIT_EN adds the p_init seed vector.
interface parity_lane_accumulator_if #(
  parameter int LANES = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic             w_valid;
  logic [LANES-1:0] w;
`ifdef PARITY_INIT_EN
  logic [LANES-1:0] p_init;
`endif
  logic [LANES-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;
  logic             drop_err;

  modport master (
`ifdef PARITY_INIT_EN
    output p_init,
`endif
    output start, w_valid, w, p_ready,
    input  p_out, p_valid, busy, word_cnt, drop_err
  );

  modport slave (
`ifdef PARITY_INIT_EN
    input  p_init,
`endif
    input  start, w_valid, w, p_ready,
    output p_out, p_valid, busy, word_cnt, drop_err
  );
endinterface

// File: rtl/parity_lane_accumulator.sv
// LANES-wide GF(2) parity accumulator over DEPTH-word frames; PARITY_INIT_EN seeds acc from p_init.
// Latency: p_valid one clock after the last accepted word; p_out is the accumulator register.
// Backpressure: HOLD until p_ready; words arriving outside ACC are dropped and flagged in drop_err.
module parity_lane_accumulator #(
  parameter int LANES = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  parity_lane_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [LANES-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [LANES-1:0] init;
  logic             do_start;

`ifdef PARITY_INIT_EN
  assign init = bus.p_init;
`else
  assign init = '0;
`endif

  // In HOLD a start only counts when it coincides with the output handshake.
  assign do_start = bus.start && ((state_q != HOLD) || bus.p_ready);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    if (do_start) begin
      acc_d   = init ^ (bus.w_valid ? bus.w : '0);
      cnt_d   = CNT_W'(bus.w_valid);
      drop_d  = 1'b0;
      state_d = ACC;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.w_valid) drop_d = 1'b1;
        end
        ACC: begin
          if (bus.w_valid) begin
            acc_d = acc_q ^ bus.w;
            // Counter saturates at DEPTH-1 so it is frozen at that value in HOLD.
            if (cnt_q == LAST) state_d = HOLD;
            else               cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.p_ready) state_d = IDLE;
          if (bus.w_valid) drop_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.p_out    = acc_q;
  assign bus.p_valid  = (state_q == HOLD);
  assign bus.busy     = (state_q == ACC);
  assign bus.word_cnt = cnt_q;
  assign bus.drop_err = drop_q;

endmodule

// File: tb/tb_parity_lane_accumulator.sv
// Directed bench for parity_lane_accumulator with LANES=16, DEPTH=4.
// Table of per-cycle vectors plus hand sequences for async reset and the init seed.
module tb_parity_lane_accumulator;

  localparam int LANES = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  typedef struct {
    logic             start;
    logic             w_valid;
    logic [LANES-1:0] w;
    logic             p_ready;
    logic [LANES-1:0] exp_p;
    logic             exp_pv;
    logic             exp_busy;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_drop;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];

  parity_lane_accumulator_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  parity_lane_accumulator #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [LANES-1:0] p, input logic pv,
                           input logic bsy, input logic [CNT_W-1:0] cnt, input logic drp);
    check({tag, " p_out"},    32'(bus.p_out),    32'(p));
    check({tag, " p_valid"},  32'(bus.p_valid),  32'(pv));
    check({tag, " busy"},     32'(bus.busy),     32'(bsy));
    check({tag, " word_cnt"}, 32'(bus.word_cnt), 32'(cnt));
    check({tag, " drop_err"}, 32'(bus.drop_err), 32'(drp));
  endtask

  task automatic drive(input logic s, input logic v, input logic [LANES-1:0] d, input logic r);
    bus.start   = s;
    bus.w_valid = v;
    bus.w       = d;
    bus.p_ready = r;
  endtask

  initial begin
    logic [LANES-1:0] exp_init;
    n_tests = 0;
    n_fail  = 0;
    drive(1'b0, 1'b0, '0, 1'b0);
`ifdef PARITY_INIT_EN
    bus.p_init = '0;
    exp_init   = 16'h1234;
`else
    exp_init   = 16'h0000;
`endif

    // Frame 1: one-hot words, immediate accept, then back to IDLE.
    tbl.push_back('{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0007, 1'b0, 1'b1, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0008, 1'b1, 16'h000F, 1'b1, 1'b0, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0, 2'd3, 1'b0});
    // Word in IDLE is dropped; flag stays set until the next start.
    tbl.push_back('{1'b0, 1'b1, 16'h5555, 1'b1, 16'h000F, 1'b0, 1'b0, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0, 2'd3, 1'b1});
    // Mid-frame restart discards 00FF and 0F0F.
    tbl.push_back('{1'b1, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0F0F, 1'b1, 16'h0FF0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'hAAAA, 1'b1, 16'hAAAA, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'h1111, 1'b1, 16'hAAAA, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0001, 1'b1, 16'hAAAB, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0010, 1'b0, 16'hAABB, 1'b0, 1'b1, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0100, 1'b0, 16'hABBB, 1'b1, 1'b0, 2'd3, 1'b0});
    // Ten cycles of backpressure: start ignored, stray word flagged, output frozen.
    for (int k = 0; k < 10; k++)
      tbl.push_back('{(k == 0), (k == 2), 16'hFFFF, 1'b0, 16'hABBB, 1'b1, 1'b0, 2'd3, (k >= 2)});
    // Handshake with start in the same cycle: straight into the next frame.
    tbl.push_back('{1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0F0F, 1'b1, 16'hF0F0, 1'b0, 1'b1, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 16'hF0F0, 1'b0, 1'b1, 2'd2, 1'b0});

    rst = 1'b0;
    #1;
    check_all("reset", '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].w_valid, tbl[i].w, tbl[i].p_ready);
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].exp_p, tbl[i].exp_pv,
                tbl[i].exp_busy, tbl[i].exp_cnt, tbl[i].exp_drop);
    end

    // Asynchronous reset mid-frame (word_cnt=2): outputs clear before any clock edge.
    drive(1'b0, 1'b0, '0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Seeded frame of four zero words: result equals the seed (zero when the seed is absent).
`ifdef PARITY_INIT_EN
    bus.p_init = 16'h1234;
`endif
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
`ifdef PARITY_INIT_EN
    bus.p_init = '0;
`endif
    check_all("init_first", exp_init, 1'b0, 1'b1, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
    end
    check_all("init_done", exp_init, 1'b1, 1'b0, 2'd3, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    check_all("init_idle", exp_init, 1'b0, 1'b0, 2'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
